mem_burst_ctrl: RTL and testbench

- Bus-master sequencer sitting directly upstream of the single-port memory; drives its addr / wr_rd / w_data / valid / ready / r_data handshake.
- Accepts one burst command, then issues sequential write beats with generated pattern data, sequential read-and-compare beats, or both.
- Reports completion, error count and pass/fail, replacing bench-driven front-door write/read tasks with synthesizable stimulus and checking.

---
 rtl/mem_burst_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer for a single-port memory: pattern writes, read-and-compare, or both.
// Optional first-mismatch capture ports are enabled by defining MEM_BURST_ERR_CAPTURE_EN.
module mem_burst_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [WIDTH-1:0]      cmd_seed,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_wr_rd,
    output logic [WIDTH-1:0]      m_w_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic [WIDTH-1:0]      m_r_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   err_cnt,
`ifdef MEM_BURST_ERR_CAPTURE_EN
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [WIDTH-1:0]      first_err_exp,
    output logic [WIDTH-1:0]      first_err_got,
    output logic                  first_err_vld,
`endif
    output logic                  pass
);

    localparam int LW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         k_q;
    logic [LW-1:0]         err_q;
    logic [WIDTH-1:0]      seed_q;
    logic [WIDTH-1:0]      pat_q;
    logic                  pass_q;

    logic                  accept;
    logic                  beat;
    logic                  last;
    logic                  mismatch;
    logic [LW-1:0]         err_nxt;
    logic [ADDR_WIDTH-1:0] addr_inc;

    assign accept   = (state == IDLE) && cmd_valid;
    assign beat     = m_valid && m_ready;
    assign last     = (k_q == len_q - LW'(1));
    assign mismatch = (state == RD) && beat && (m_r_data != pat_q);
    assign err_nxt  = (mismatch && (err_q != '1)) ? err_q + LW'(1) : err_q;
    // explicit wrap so DEPTH need not be a power of two
    assign addr_inc = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                          : addr_q + ADDR_WIDTH'(1);

    assign m_addr   = addr_q;
    assign m_w_data = pat_q;
    assign err_cnt  = err_q;
    assign pass     = pass_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        m_valid   = 1'b0;
        m_wr_rd   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_len == '0 || cmd_op == 2'b11) begin
                        state_nxt = FIN;
                    end else if (cmd_op == 2'b01) begin
                        state_nxt = RD;
                    end else begin
                        state_nxt = WR;
                    end
                end
            end
            WR: begin
                m_valid = 1'b1;
                m_wr_rd = 1'b1;
                if (m_ready && last) begin
                    state_nxt = (op_q == 2'b10) ? RD : FIN;
                end
            end
            RD: begin
                m_valid = 1'b1;
                if (m_ready && last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            base_q <= '0;
            addr_q <= '0;
            len_q  <= '0;
            k_q    <= '0;
            err_q  <= '0;
            seed_q <= '0;
            pat_q  <= '0;
            pass_q <= 1'b0;
        end else if (accept) begin
            op_q   <= cmd_op;
            base_q <= cmd_addr;
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            k_q    <= '0;
            err_q  <= '0;
            seed_q <= cmd_seed;
            pat_q  <= cmd_seed;
            // a zero-length burst finishes straight away, so pass is known now
            pass_q <= (cmd_op != 2'b11) && (cmd_len == '0);
        end else if (beat) begin
            err_q <= err_nxt;
            if (!last) begin
                k_q    <= k_q + LW'(1);
                addr_q <= addr_inc;
                pat_q  <= pat_q + WIDTH'(1);
            end else if (state == WR && op_q == 2'b10) begin
                k_q    <= '0;
                addr_q <= base_q;
                pat_q  <= seed_q;
            end else begin
                pass_q <= (err_nxt == '0);
            end
        end
    end

`ifdef MEM_BURST_ERR_CAPTURE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            first_err_vld  <= 1'b0;
        end else if (accept) begin
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            first_err_vld  <= 1'b0;
        end else if (mismatch && !first_err_vld) begin
            first_err_addr <= addr_q;
            first_err_exp  <= pat_q;
            first_err_got  <= m_r_data;
            first_err_vld  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Testbench for mem_burst_ctrl: memory model, beat scoreboard, scenario tasks.
// Capture-port checks are included when MEM_BURST_ERR_CAPTURE_EN is defined.
module tb_mem_burst_ctrl;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic [W-1:0]  cmd_seed = '0;
    logic [AW-1:0] m_addr;
    logic          m_wr_rd;
    logic [W-1:0]  m_w_data;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_r_data;
    logic          busy;
    logic          done;
    logic [AW:0]   err_cnt;
    logic          pass;
`ifdef MEM_BURST_ERR_CAPTURE_EN
    logic [AW-1:0] first_err_addr;
    logic [W-1:0]  first_err_exp;
    logic [W-1:0]  first_err_got;
    logic          first_err_vld;
`endif

    always #5 clk = ~clk;

    mem_burst_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .cmd_seed(cmd_seed),
        .m_addr(m_addr),
        .m_wr_rd(m_wr_rd),
        .m_w_data(m_w_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_r_data(m_r_data),
        .busy(busy),
        .done(done),
        .err_cnt(err_cnt),
`ifdef MEM_BURST_ERR_CAPTURE_EN
        .first_err_addr(first_err_addr),
        .first_err_exp(first_err_exp),
        .first_err_got(first_err_got),
        .first_err_vld(first_err_vld),
`endif
        .pass(pass)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } beat_t;

    beat_t sb[$];
    beat_t e;
    int checks = 0;
    int failures = 0;

    logic [W-1:0] mem [D];
    logic tog_en = 1'b0;
    logic tog_q = 1'b0;
    logic corrupt_on = 1'b0;

    always @(posedge clk) tog_q <= ~tog_q;
    assign m_ready = tog_en ? tog_q : 1'b1;
    assign m_r_data = mem[m_addr] ^ ((corrupt_on && m_addr == 4'd3) ? 8'h01 : 8'h00);

    always @(posedge clk)
        if (rst && m_valid && m_ready && m_wr_rd) mem[m_addr] <= m_w_data;

    // beat monitor: every accepted beat is popped against the scoreboard
    logic          stall_q = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [W-1:0]  st_data = '0;

    always @(negedge clk) begin
        if (rst && m_valid) begin
            if (stall_q) begin
                checks++;
                if (m_addr !== st_addr || m_w_data !== st_data) begin
                    failures++;
                    $display("FAIL stall_hold got addr=%0d data=%h want addr=%0d data=%h",
                             m_addr, m_w_data, st_addr, st_data);
                end
            end
            if (m_ready) begin
                stall_q = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL beat_extra got wr=%0b addr=%0d data=%h want none",
                             m_wr_rd, m_addr, m_w_data);
                end else begin
                    e = sb.pop_front();
                    if (m_wr_rd !== e.wr || m_addr !== e.addr ||
                        (e.wr && m_w_data !== e.data)) begin
                        failures++;
                        $display("FAIL beat got wr=%0b addr=%0d data=%h want wr=%0b addr=%0d data=%h",
                                 m_wr_rd, m_addr, m_w_data, e.wr, e.addr, e.data);
                    end
                end
            end else begin
                stall_q = 1'b1;
                st_addr = m_addr;
                st_data = m_w_data;
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    // called at a negedge; returns just after the accepting edge
    task automatic issue(input logic [1:0] op, input int addr, input int len,
                         input int seed);
        if (op != 2'b11) begin
            if (op == 2'b00 || op == 2'b10)
                for (int k = 0; k < len; k++)
                    sb.push_back(beat_t'{1'b1, AW'((addr + k) % D), W'(seed + k)});
            if (op == 2'b01 || op == 2'b10)
                for (int k = 0; k < len; k++)
                    sb.push_back(beat_t'{1'b0, AW'((addr + k) % D), W'(seed + k)});
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW + 1)'(len);
        cmd_seed  = W'(seed);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (done) begin
                cyc = c;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold got m_valid=%0b cmd_ready=%0b want 0 1", m_valid, cmd_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_valid, m_wr_rd, busy, done, pass} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl got v=%0b wr=%0b busy=%0b done=%0b pass=%0b want 0",
                     m_valid, m_wr_rd, busy, done, pass);
        end
        checks++;
        if (m_addr !== '0 || m_w_data !== '0 || err_cnt !== '0) begin
            failures++;
            $display("FAIL reset_data got addr=%0d data=%h err=%0d want 0",
                     m_addr, m_w_data, err_cnt);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %0b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_check();
        int cyc;
        @(negedge clk);
        issue(2'b10, 0, 16, 8'h10);
        wait_done(cyc);
        checks++;
        if (cyc != 33) begin
            failures++;
            $display("FAIL wc_latency got %0d want 33", cyc);
        end
        checks++;
        if (err_cnt !== '0 || pass !== 1'b1) begin
            failures++;
            $display("FAIL wc_result got err=%0d pass=%0b want 0 1", err_cnt, pass);
        end
        checks++;
        if (sb.size() != 0 || mem[15] !== 8'h1F) begin
            failures++;
            $display("FAIL wc_beats got left=%0d mem15=%h want 0 1f", sb.size(), mem[15]);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        @(negedge clk);
        issue(2'b00, 14, 4, 8'hA0);
        wait_done(cyc);
        checks++;
        if (cyc != 5 || sb.size() != 0) begin
            failures++;
            $display("FAIL wrap_wr got cyc=%0d left=%0d want 5 0", cyc, sb.size());
        end
        @(negedge clk);
        issue(2'b01, 14, 4, 8'hA0);
        wait_done(cyc);
        checks++;
        if (cyc != 5 || err_cnt !== '0 || pass !== 1'b1) begin
            failures++;
            $display("FAIL wrap_rd got cyc=%0d err=%0d pass=%0b want 5 0 1", cyc, err_cnt, pass);
        end
    endtask

    task automatic test_corrupt();
        int cyc;
        corrupt_on = 1'b1;
        @(negedge clk);
        issue(2'b10, 0, 8, 8'h00);
        wait_done(cyc);
        checks++;
        if (cyc != 17 || err_cnt !== 5'd1 || pass !== 1'b0) begin
            failures++;
            $display("FAIL corrupt got cyc=%0d err=%0d pass=%0b want 17 1 0", cyc, err_cnt, pass);
        end
`ifdef MEM_BURST_ERR_CAPTURE_EN
        checks++;
        if (first_err_vld !== 1'b1 || first_err_addr !== 4'd3 ||
            first_err_exp !== 8'h03 || first_err_got !== 8'h02) begin
            failures++;
            $display("FAIL capture got vld=%0b addr=%0d exp=%h got=%h want 1 3 03 02",
                     first_err_vld, first_err_addr, first_err_exp, first_err_got);
        end
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt !== 5'd1 || pass !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL corrupt_hold got err=%0d pass=%0b busy=%0b want 1 0 0",
                     err_cnt, pass, busy);
        end
        corrupt_on = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        while (tog_q !== 1'b1) @(negedge clk);
        tog_en = 1'b1;
        issue(2'b00, 2, 4, 8'h50);
        wait_done(cyc);
        checks++;
        if (cyc != 9 || sb.size() != 0) begin
            failures++;
            $display("FAIL backpressure got cyc=%0d left=%0d want 9 0", cyc, sb.size());
        end
        tog_en = 1'b0;
    endtask

    task automatic test_len_zero();
        int cyc;
        @(negedge clk);
        issue(2'b00, 5, 0, 8'h33);
        wait_done(cyc);
        checks++;
        if (cyc != 1 || pass !== 1'b1 || err_cnt !== '0) begin
            failures++;
            $display("FAIL len_zero got cyc=%0d pass=%0b err=%0d want 1 1 0", cyc, pass, err_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        @(negedge clk);
        issue(2'b00, 0, 16, 8'h40);
        repeat (5) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 4'd4) begin
            failures++;
            $display("FAIL mid_pre got v=%0b addr=%0d want 1 4", m_valid, m_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got v=%0b busy=%0b ready=%0b want 0 0 1",
                     m_valid, busy, cmd_ready);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got ready=%0b v=%0b want 1 0", cmd_ready, m_valid);
        end
        issue(2'b10, 5, 3, 8'h77);
        wait_done(cyc);
        checks++;
        if (cyc != 7 || err_cnt !== '0 || pass !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL post_cmd got cyc=%0d err=%0d pass=%0b left=%0d want 7 0 1 0",
                     cyc, err_cnt, pass, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_check();
        test_wrap();
        test_corrupt();
        test_backpressure();
        test_len_zero();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
